// File: rtl/lsu_pkg.sv
`default_nettype none
// lsu_pkg: shared types for the load/store unit and its data-memory bridge.
// Rev 1.0
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bridge_state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_BUS_ERR = 2'b01,
    FC_TIMEOUT = 2'b10
  } fault_cause_t;

endpackage
`default_nettype wire

// File: rtl/dmem_timeout_ctr.sv
`default_nettype none
// dmem_timeout_ctr: counts response-wait cycles and flags the last allowed one.
// Rev 1.0
module dmem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

      logic [CNT_WIDTH-1:0] cnt_q;

      // Saturates at LAST so a missed consumer can never wrap back to zero.
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          cnt_q <= '0;
        end else if (clr) begin
          cnt_q <= '0;
        end else if (en && (cnt_q != LAST)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign expired = (cnt_q == LAST);
    end else begin : g_no_timeout
      logic unused_inputs;
      assign unused_inputs = ^{clk, arst_n, clr, en};
      assign expired       = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// dmem_bridge: runs one LSU memory instruction as a valid/ready bus transaction,
// stalling the pipeline until the response (or a timeout) completes it. Rev 1.0
module dmem_bridge
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_mask,
  output logic                    stall,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    fault,
  output logic [1:0]              fault_cause,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
  input  logic                    mem_rsp_err
);

  localparam int MASK_SIZE = DATA_WIDTH / 8;

  bridge_state_t         state_q, state_d;
  fault_cause_t          fc_q, fc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_SIZE-1:0]  mask_q, mask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  orphan_q, orphan_d;

  logic tmo_clr, tmo_en, tmo_expired;
  logic unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];

  dmem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d       = state_q;
    fc_d          = fc_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mask_d        = mask_q;
    rdata_d       = rdata_q;
    orphan_d      = orphan_q;
    stall         = 1'b0;
    done          = 1'b0;
    mem_req_valid = 1'b0;
    tmo_clr       = 1'b0;
    tmo_en        = 1'b0;

    // The late response of a timed-out request may land in any state; swallow it.
    if (orphan_q && mem_rsp_valid) begin
      orphan_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          stall   = 1'b1;
          we_d    = req_we;
          addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d = req_wdata;
          mask_d  = req_we ? req_mask : '0;
          if (req_we && (req_mask == '0)) begin
            fc_d    = FC_NONE;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall         = 1'b1;
        mem_req_valid = !orphan_q;
        if (!orphan_q && mem_req_ready) begin
          tmo_clr = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall  = 1'b1;
        tmo_en = 1'b1;
        if (mem_rsp_valid) begin
          if (!we_q) begin
            rdata_d = mem_rsp_rdata;
          end
          fc_d    = mem_rsp_err ? FC_BUS_ERR : FC_NONE;
          state_d = DONE;
        end else if (tmo_expired) begin
          fc_d     = FC_TIMEOUT;
          orphan_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      fc_q     <= FC_NONE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fc_q     <= fc_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      orphan_q <= orphan_d;
    end
  end

  assign rdata       = rdata_q;
  assign fault_cause = fc_q;
  assign fault       = (state_q == DONE) && (fc_q != FC_NONE);
  assign mem_addr    = addr_q;
  assign mem_we      = we_q;
  assign mem_wdata   = wdata_q;
  assign mem_wmask   = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// tb_dmem_bridge: directed self-checking bench for dmem_bridge (TIMEOUT_CYCLES=4).
// Rev 1.0
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_mask = '0;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic [1:0]  fault_cause;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;
  logic        mem_rsp_err = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_bridge #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_mask     (req_mask),
    .stall        (stall),
    .done         (done),
    .rdata        (rdata),
    .fault        (fault),
    .fault_cause  (fault_cause),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err  (mem_rsp_err)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++; if ({stall, done, fault, mem_req_valid} !== 4'b0000) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", {stall, done, fault, mem_req_valid}); end
    n_cmp++; if ({rdata, mem_addr, mem_wdata} !== 96'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", {rdata, mem_addr, mem_wdata}); end
    n_cmp++; if ({fault_cause, mem_we, mem_wmask} !== 7'b0) begin n_err++; $display("FAIL reset_misc: got %b want 0", {fault_cause, mem_we, mem_wmask}); end
    arst_n = 1'b1;
    cyc();
  endtask

  task automatic test_load();
    // cycle 0
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1006; req_mask = 4'hF; mem_req_ready = 1'b1;
    #1;
    n_cmp++; if ({stall, mem_req_valid, done} !== 3'b100) begin n_err++; $display("FAIL load_c0: got %b want 100", {stall, mem_req_valid, done}); end
    cyc(); #1;
    n_cmp++; if ({stall, mem_req_valid, mem_we} !== 3'b110) begin n_err++; $display("FAIL load_c1_ctrl: got %b want 110", {stall, mem_req_valid, mem_we}); end
    n_cmp++; if (mem_addr !== 32'h1004) begin n_err++; $display("FAIL load_addr: got %h want 00001004", mem_addr); end
    n_cmp++; if (mem_wmask !== 4'b0000) begin n_err++; $display("FAIL load_wmask: got %b want 0000", mem_wmask); end
    cyc();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hAABBCCDD;
    #1;
    n_cmp++; if ({stall, mem_req_valid, done} !== 3'b100) begin n_err++; $display("FAIL load_c2: got %b want 100", {stall, mem_req_valid, done}); end
    cyc();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({done, stall, fault, fault_cause} !== 5'b10000) begin n_err++; $display("FAIL load_c3_done: got %b want 10000", {done, stall, fault, fault_cause}); end
    n_cmp++; if (rdata !== 32'hAABBCCDD) begin n_err++; $display("FAIL load_rdata: got %h want aabbccdd", rdata); end
    cyc();
    req_valid = 1'b0;
    #1;
    n_cmp++; if ({done, stall} !== 2'b00) begin n_err++; $display("FAIL load_c4: got %b want 00", {done, stall}); end
  endtask

  task automatic test_store_backpressure();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2002; req_wdata = 32'h12340000; req_mask = 4'b1100;
    mem_req_ready = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL st_c0_stall: got %b want 1", stall); end
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if ({stall, mem_req_valid, mem_we, mem_wmask, mem_addr, mem_wdata} !== {3'b111, 4'b1100, 32'h2000, 32'h12340000})
        begin n_err++; $display("FAIL st_hold%0d: got %b %b %b %b %h %h", i, stall, mem_req_valid, mem_we, mem_wmask, mem_addr, mem_wdata); end
      cyc();
    end
    mem_req_ready = 1'b1;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL st_accept: got %b want 1", mem_req_valid); end
    cyc();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEADBEEF; mem_rsp_err = 1'b0;
    #1;
    n_cmp++; if ({stall, done} !== 2'b10) begin n_err++; $display("FAIL st_wait: got %b want 10", {stall, done}); end
    cyc();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({done, stall, fault} !== 3'b100) begin n_err++; $display("FAIL st_done: got %b want 100", {done, stall, fault}); end
    n_cmp++; if (rdata !== 32'hAABBCCDD) begin n_err++; $display("FAIL st_rdata_kept: got %h want aabbccdd", rdata); end
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic test_masked_store();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h3000; req_wdata = 32'hFFFFFFFF; req_mask = 4'b0000;
    mem_req_ready = 1'b1;
    #1;
    n_cmp++; if ({stall, mem_req_valid, done} !== 3'b100) begin n_err++; $display("FAIL ms_c0: got %b want 100", {stall, mem_req_valid, done}); end
    cyc(); #1;
    n_cmp++; if ({done, stall, mem_req_valid, fault, fault_cause} !== 6'b100000) begin n_err++; $display("FAIL ms_c1: got %b want 100000", {done, stall, mem_req_valid, fault, fault_cause}); end
    cyc();
    req_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    n_cmp++; if ({done, stall, mem_req_valid} !== 3'b000) begin n_err++; $display("FAIL ms_c2: got %b want 000", {done, stall, mem_req_valid}); end
  endtask

  task automatic test_bus_error();
    cyc();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3000; req_mask = 4'hF; mem_req_ready = 1'b1;
    cyc();
    cyc();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1; mem_rsp_rdata = 32'h55555555;
    cyc();
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    #1;
    n_cmp++; if ({done, fault, fault_cause} !== 4'b1101) begin n_err++; $display("FAIL err_done: got %b want 1101", {done, fault, fault_cause}); end
    n_cmp++; if (rdata !== 32'h55555555) begin n_err++; $display("FAIL err_rdata: got %h want 55555555", rdata); end
    cyc();
    req_valid = 1'b0;
    #1;
    n_cmp++; if ({done, fault, fault_cause} !== 4'b0001) begin n_err++; $display("FAIL err_hold: got %b want 0001", {done, fault, fault_cause}); end
  endtask

  task automatic test_timeout_orphan();
    cyc();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4008; req_mask = 4'hF; mem_req_ready = 1'b1;
    cyc();
    cyc();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if ({stall, done} !== 2'b10) begin n_err++; $display("FAIL to_wait%0d: got %b want 10", i, {stall, done}); end
      cyc();
    end
    #1;
    n_cmp++; if ({done, fault, fault_cause} !== 4'b1110) begin n_err++; $display("FAIL to_done: got %b want 1110", {done, fault, fault_cause}); end
    n_cmp++; if (rdata !== 32'h55555555) begin n_err++; $display("FAIL to_rdata: got %h want 55555555", rdata); end
    cyc();
    req_valid = 1'b0;
    cyc();
    req_valid = 1'b1; req_addr = 32'h5000;
    cyc();
    mem_req_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if ({stall, mem_req_valid} !== 2'b10) begin n_err++; $display("FAIL orph_block%0d: got %b want 10", i, {stall, mem_req_valid}); end
      cyc();
    end
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBADBAD00;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL orph_rsp_cycle: got %b want 0", mem_req_valid); end
    cyc();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({mem_req_valid, mem_addr} !== {1'b1, 32'h5000}) begin n_err++; $display("FAIL orph_issue: got %b %h want 1 00005000", mem_req_valid, mem_addr); end
    n_cmp++; if (rdata !== 32'h55555555) begin n_err++; $display("FAIL orph_no_leak: got %h want 55555555", rdata); end
    cyc();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h600DF00D;
    #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL orph_wait: got %b want 0", done); end
    cyc();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({done, fault, fault_cause} !== 4'b1000) begin n_err++; $display("FAIL orph_done: got %b want 1000", {done, fault, fault_cause}); end
    n_cmp++; if (rdata !== 32'h600DF00D) begin n_err++; $display("FAIL orph_rdata: got %h want 600df00d", rdata); end
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    cyc();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h6000; req_mask = 4'hF; mem_req_ready = 1'b1;
    cyc();
    cyc();
    mem_req_ready = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL ar_in_wait: got %b want 1", stall); end
    arst_n = 1'b0; req_valid = 1'b0;
    #1;
    n_cmp++; if ({stall, done, fault, mem_req_valid, fault_cause} !== 6'b0) begin n_err++; $display("FAIL ar_ctrl: got %b want 000000", {stall, done, fault, mem_req_valid, fault_cause}); end
    n_cmp++; if ({rdata, mem_addr} !== 64'h0) begin n_err++; $display("FAIL ar_data: got %h want 0", {rdata, mem_addr}); end
    @(posedge clk);
    #3;
    arst_n = 1'b1;
    cyc();
    req_valid = 1'b1; req_addr = 32'h7004; mem_req_ready = 1'b1;
    cyc();
    #1;
    n_cmp++; if ({mem_req_valid, mem_addr} !== {1'b1, 32'h7004}) begin n_err++; $display("FAIL ar_reissue: got %b %h want 1 00007004", mem_req_valid, mem_addr); end
    cyc();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h13579BDF;
    cyc();
    mem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if ({done, fault, rdata} !== {2'b10, 32'h13579BDF}) begin n_err++; $display("FAIL ar_done: got %b %b %h want 1 0 13579bdf", done, fault, rdata); end
    cyc();
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_store_backpressure();
    test_masked_store();
    test_bus_error();
    test_timeout_orphan();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the load/store unit, between it and the data memory.
- Takes one aligned-lane request per instruction (word address, store data, byte mask, we) and runs it as a valid/ready request plus response-valid transaction on the memory bus.
- Stalls the pipeline until the transaction completes, then returns raw read data to the LSU load path.
- Reports bus errors and response timeouts as a fault.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, address width
MASK_SIZE, DATA_WIDTH/8, byte-enable width (localparam)
TIMEOUT_CYCLES, 64, max cycles waiting for a response; 0 disables timeout
CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), timeout counter width (localparam)

Ports:
clk  in  1  clock, rising edge
arst_n  in  1  asynchronous active-low reset
req_valid  in  1  pipeline presents a memory instruction; held until stall falls
req_we  in  1  1=store, 0=load
req_addr  in  ADDR_WIDTH  byte address from LSU addr_out
req_wdata  in  DATA_WIDTH  lane-placed store data from LSU data_s_out
req_mask  in  MASK_SIZE  byte enables from LSU mask
stall  out  1  freeze pipeline stage
done  out  1  one-cycle completion pulse
rdata  out  DATA_WIDTH  raw load word to LSU data_l_in
fault  out  1  completion carried an error (valid with done)
fault_cause  out  2  00 none, 01 bus error, 10 timeout
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_addr  out  ADDR_WIDTH  word-aligned address
mem_we  out  1  write enable
mem_wdata  out  DATA_WIDTH  write data
mem_wmask  out  MASK_SIZE  byte enables; 0 for loads
mem_rsp_valid  in  1  response valid, at least 1 cycle after acceptance
mem_rsp_rdata  in  DATA_WIDTH  response data
mem_rsp_err  in  1  response error, qualified by mem_rsp_valid

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (arst_n).
- Reset values: state=IDLE; all outputs 0; latched request, counter and orphan flag cleared. Reset mid-transaction abandons it; the memory side is reset by the same arst_n.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, req_valid=0: stay in IDLE.
- IDLE, req_valid=1:
  - latch req_we, wdata, mask, and {addr[ADDR_WIDTH-1:2],2'b00}.
  - store with mask=0: go to DONE, no bus transaction.
  - otherwise: go to REQ.
- REQ:
  - mem_req_valid = !orphan.
  - mem_addr/we/wdata/wmask are driven from latched values and stay stable while valid && !ready.
  - on valid && ready: clear counter, go to WAIT.
  - mem_rsp_valid is ignored in REQ unless orphan=1; then it clears orphan.
- WAIT:
  - counter increments each cycle.
  - on mem_rsp_valid: rdata <= mem_rsp_rdata for loads (unchanged for stores); fault_cause <= err ? 01 : 00; go to DONE.
  - TIMEOUT_CYCLES>0 and counter==TIMEOUT_CYCLES-1 without response: fault_cause <= 10; set orphan; go to DONE.
  - A response in the same cycle as the timeout wins; no timeout is raised.
- DONE:
  - done=1; fault=(fault_cause!=00); stall=0.
  - next cycle go to IDLE; req_valid in this cycle is the finished instruction and is ignored.
- stall = (IDLE && req_valid) || REQ || WAIT. Combinational, so stall asserts in the same cycle as the request.
- Latency with an ideal bus (ready=1 in REQ, response 1 cycle later): request in cycle 0, done in cycle 3, stall high in cycles 0-2. A masked-off store has done in cycle 1.
- Orphan: a late response to a timed-out request is discarded and never presented as data for the next request.
- rdata holds its value until the next load completes; fault_cause holds until the next completion.

Decomposition:
- lsu_pkg gains:
  - bridge_state_t enum {IDLE, REQ, WAIT, DONE}
  - fault_cause_t enum {FC_NONE=2'b00, FC_BUS_ERR=2'b01, FC_TIMEOUT=2'b10}
- One sub-module: dmem_timeout_ctr.
  - inputs: clk, arst_n, clr, en
  - output: expired
  - parameter: TIMEOUT_CYCLES
  - expired is tied 0 when TIMEOUT_CYCLES=0.
- FSM, request latches and orphan flag stay in dmem_bridge.

Test Plan:
1. Load at addr 0x1006; ready=1; rsp 1 cycle later with rdata 0xAABBCCDD -> mem_addr=0x1004, wmask=0000; done in cycle 3; rdata=0xAABBCCDD; fault=0.
2. Store addr 0x2002, wdata 0x12340000, mask 1100; ready held low 4 cycles -> mem_req_valid and all fields stable for 4 cycles; stall high throughout; done after response; rdata unchanged.
3. Store with mask 0000 -> no mem_req_valid; done pulse in cycle 1; stall high only in cycle 0.
4. Load with mem_rsp_err=1 -> done with fault=1, fault_cause=01.
5. TIMEOUT_CYCLES=4, no response -> fault_cause=10 after 4 WAIT cycles. Next load holds mem_req_valid=0 until the late response arrives, then issues normally; the late data never appears on rdata.
6. Assert arst_n low while in WAIT -> outputs 0 and state IDLE immediately, without a clock edge; a fresh load after release completes normally.
